// File: rtl/traffic_pkg.sv
// Shared definitions between farm_sensor_conditioner and traffic_signal.
//   FARM_GREEN / YELLOW / RED : 2-bit farm light encoding (2'b11 is illegal)
//   cond_state_t              : conditioner demand FSM states
//   is_farm_green()           : true only for the green encoding
package traffic_pkg;

    localparam logic [1:0] FARM_GREEN = 2'b00;
    localparam logic [1:0] YELLOW     = 2'b01;
    localparam logic [1:0] RED        = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        DEMAND  = 2'b01,
        SERVING = 2'b10,
        FAULT   = 2'b11
    } cond_state_t;

    // The illegal encoding 2'b11 falls out as not-green.
    function automatic logic is_farm_green(input logic [1:0] sig);
        return (sig == FARM_GREEN);
    endfunction

endpackage

// File: rtl/loop_debouncer.sv
// Synchronizer plus debounce filter for a vehicle loop detector.
//   i_clk     : clock, rising edge
//   i_rst     : synchronous active-high reset
//   i_raw     : asynchronous loop level
//   o_loop_db : debounced level; changes only after DEBOUNCE_CYCLES
//               consecutive synchronized samples disagree with it
module loop_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_loop_db
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_deb_cnt;
    logic                   r_loop_db;
    logic                   w_loop_s;

    assign w_loop_s  = r_sync[SYNC_STAGES-1];
    assign o_loop_db = r_loop_db;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    // Count consecutive disagreeing samples; any agreeing sample restarts the run.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_deb_cnt <= '0;
            r_loop_db <= 1'b0;
        end else if (w_loop_s != r_loop_db) begin
            if (r_deb_cnt == DEB_LAST) begin
                r_loop_db <= ~r_loop_db;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end else begin
            r_deb_cnt <= '0;
        end
    end

endmodule

// File: rtl/farm_sensor_conditioner.sv
// Farm-road demand conditioner feeding traffic_signal.
//   clk           : clock, rising edge
//   rst           : synchronous active-high reset
//   raw_loop      : asynchronous loop-detector level
//   farm_signal   : farm light state fed back from traffic_signal
//   sensor        : clean, latched farm-road demand
//   stuck_fault   : loop detector stuck high
//   vehicle_count : saturating count of debounced arrivals
//
// state   | meaning
// IDLE    | no demand, sensor = 0
// DEMAND  | demand latched until farm goes green, sensor = 1
// SERVING | farm green, sensor follows debounced loop (green extension)
// FAULT   | detector stuck high, sensor = 1, stuck_fault = 1
import traffic_pkg::*;

module farm_sensor_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int STUCK_CYCLES    = 4096,
    parameter int COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               raw_loop,
    input  logic [1:0]         farm_signal,
    output logic               sensor,
    output logic               stuck_fault,
    output logic [COUNT_W-1:0] vehicle_count
);

    localparam int STUCK_W = $clog2(STUCK_CYCLES + 1);
    localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_CYCLES);

    logic               w_loop_db;
    logic               r_loop_db_d;
    logic               w_rise_db;
    logic               w_farm_green;
    logic               w_stuck_hit;
    logic [STUCK_W-1:0] r_stuck_cnt;
    logic [COUNT_W-1:0] r_vehicle_cnt;
    cond_state_t        r_state;
    cond_state_t        w_state_nxt;

    loop_debouncer #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_loop_debouncer (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_raw     (raw_loop),
        .o_loop_db (w_loop_db)
    );

    assign w_rise_db     = w_loop_db & ~r_loop_db_d;
    assign w_farm_green  = is_farm_green(farm_signal);
    // Qualified by the live level so a released detector can leave FAULT as
    // soon as loop_db drops, one cycle before the counter itself clears.
    assign w_stuck_hit   = w_loop_db && (r_stuck_cnt == STUCK_MAX);
    assign vehicle_count = r_vehicle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_loop_db_d   <= 1'b0;
            r_stuck_cnt   <= '0;
            r_vehicle_cnt <= '0;
        end else begin
            r_loop_db_d <= w_loop_db;

            if (!w_loop_db) begin
                r_stuck_cnt <= '0;
            end else if (r_stuck_cnt != STUCK_MAX) begin
                r_stuck_cnt <= r_stuck_cnt + 1'b1;
            end

            if (w_rise_db && (r_vehicle_cnt != '1)) begin
                r_vehicle_cnt <= r_vehicle_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        sensor      = 1'b0;
        stuck_fault = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise_db) begin
                    w_state_nxt = DEMAND;
                end
            end
            DEMAND: begin
                sensor = 1'b1;
                if (w_farm_green) begin
                    w_state_nxt = SERVING;
                end
            end
            SERVING: begin
                sensor = w_loop_db;
                if (!w_farm_green) begin
                    w_state_nxt = w_loop_db ? DEMAND : IDLE;
                end
            end
            FAULT: begin
                sensor      = 1'b1;
                stuck_fault = 1'b1;
                if (!w_loop_db) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_stuck_hit) begin
            w_state_nxt = FAULT;
        end
    end

endmodule

// File: tb/tb_farm_sensor_conditioner.sv
`timescale 1ns/100ps
module tb_farm_sensor_conditioner;

    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int STUCK = 64;

    localparam logic [1:0] GREEN_C  = 2'b00;
    localparam logic [1:0] YELLOW_C = 2'b01;
    localparam logic [1:0] RED_C    = 2'b10;

    logic       clk = 1'b0;
    logic       rst;
    logic       raw_loop;
    logic [1:0] farm_signal;
    logic       sensor, stuck_fault;
    logic [7:0] vehicle_count;
    logic       sensor2, stuck2;
    logic [1:0] vehicle_count2;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 0;

    always #1 clk = ~clk;

    farm_sensor_conditioner #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .STUCK_CYCLES(STUCK), .COUNT_W(8)
    ) u_dut (
        .clk(clk), .rst(rst), .raw_loop(raw_loop), .farm_signal(farm_signal),
        .sensor(sensor), .stuck_fault(stuck_fault), .vehicle_count(vehicle_count)
    );

    farm_sensor_conditioner #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .STUCK_CYCLES(STUCK), .COUNT_W(2)
    ) u_dut2 (
        .clk(clk), .rst(rst), .raw_loop(raw_loop), .farm_signal(farm_signal),
        .sensor(sensor2), .stuck_fault(stuck2), .vehicle_count(vehicle_count2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Debounced level flips once the last DEB synchronized samples all differ
    // from it; a synchronized sample seen at an edge is the raw value taken
    // SYNC edges earlier, so the window is raw samples h[SYNC .. SYNC+DEB-1].
    localparam int M_IDLE = 0, M_DEMAND = 1, M_SERVING = 2, M_FAULT = 3;
    bit h[0:15];
    bit m_db, m_db_prev;
    int m_stuck, m_cnt, m_cnt2, m_mode;

    function automatic bit m_sensor();
        case (m_mode)
            M_DEMAND, M_FAULT: return 1'b1;
            M_SERVING:         return m_db;
            default:           return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        bit rise, green, flip;
        int nm;
        for (int i = 15; i > 0; i--) h[i] = h[i-1];
        h[0] = rst ? 1'b0 : raw_loop;
        if (rst) begin
            m_db = 0; m_db_prev = 0; m_stuck = 0; m_cnt = 0; m_cnt2 = 0; m_mode = M_IDLE;
        end else begin
            rise  = m_db && !m_db_prev;
            green = (farm_signal == GREEN_C);
            nm    = m_mode;
            if (m_db && m_stuck == STUCK) nm = M_FAULT;
            else if (m_mode == M_IDLE    && rise)   nm = M_DEMAND;
            else if (m_mode == M_DEMAND  && green)  nm = M_SERVING;
            else if (m_mode == M_SERVING && !green) nm = m_db ? M_DEMAND : M_IDLE;
            else if (m_mode == M_FAULT   && !m_db)  nm = M_IDLE;
            if (rise) begin
                m_cnt  = (m_cnt  < 255) ? m_cnt + 1  : 255;
                m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
            end
            m_stuck = m_db ? ((m_stuck < STUCK) ? m_stuck + 1 : STUCK) : 0;
            flip = 1'b1;
            for (int i = SYNC; i < SYNC + DEB; i++) if (h[i] == m_db) flip = 1'b0;
            m_db_prev = m_db;
            if (flip) m_db = !m_db;
            m_mode = nm;
        end
    end

    always @(posedge clk) begin
        #0.5;
        if (cmp_en) begin
            check("model_sensor", 32'(sensor), 32'(m_sensor()));
            check("model_stuck", 32'(stuck_fault), 32'(m_mode == M_FAULT));
            check("model_count", 32'(vehicle_count), 32'(m_cnt));
            check("model_sensor_w2", 32'(sensor2), 32'(m_sensor()));
            check("model_count_w2", 32'(vehicle_count2), 32'(m_cnt2));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; raw_loop = 1'b0; farm_signal = RED_C;
        @(negedge clk);
        cmp_en = 1;

        // reset with the loop toggling
        for (int i = 0; i < 10; i++) begin
            raw_loop = ~raw_loop;
            check("rst_sensor", 32'(sensor), 32'd0);
            tick(1);
        end
        rst = 1'b0; raw_loop = 1'b0;
        tick(1);
        check("post_rst_sensor", 32'(sensor), 32'd0);
        check("post_rst_stuck", 32'(stuck_fault), 32'd0);
        check("post_rst_count", 32'(vehicle_count), 32'd0);
        tick(10);

        // glitch of 3 cycles
        raw_loop = 1'b1; tick(3); raw_loop = 1'b0; tick(15);
        check("glitch_sensor", 32'(sensor), 32'd0);
        check("glitch_count", 32'(vehicle_count), 32'd0);

        // demand latch: sensor rises exactly 7 edges after the rise
        raw_loop = 1'b1;
        tick(6); check("latency_6", 32'(sensor), 32'd0);
        tick(1); check("latency_7", 32'(sensor), 32'd1);
        tick(3); raw_loop = 1'b0;
        tick(15);
        check("latched_sensor", 32'(sensor), 32'd1);
        check("latched_count", 32'(vehicle_count), 32'd1);
        farm_signal = GREEN_C; tick(3);
        check("serving_clear", 32'(sensor), 32'd0);
        farm_signal = RED_C; tick(5);
        check("idle_sensor", 32'(sensor), 32'd0);

        // re-demand while the vehicle stays
        raw_loop = 1'b1; tick(10);
        farm_signal = GREEN_C; tick(3);
        check("serving_present", 32'(sensor), 32'd1);
        farm_signal = YELLOW_C;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("redemand_hold", 32'(sensor), 32'd1);
        end
        raw_loop = 1'b0; tick(10);
        farm_signal = GREEN_C; tick(20);
        farm_signal = RED_C; tick(5);
        check("redemand_count", 32'(vehicle_count), 32'd2);

        // stuck detector while green: fault 71 edges after the rise
        farm_signal = GREEN_C; raw_loop = 1'b1;
        tick(70); check("stuck_before", 32'(stuck_fault), 32'd0);
        tick(1);  check("stuck_set", 32'(stuck_fault), 32'd1);
        check("stuck_sensor", 32'(sensor), 32'd1);
        tick(10);
        raw_loop = 1'b0;
        tick(6); check("stuck_hold", 32'(stuck_fault), 32'd1);
        tick(1); check("stuck_clear", 32'(stuck_fault), 32'd0);
        farm_signal = RED_C; tick(5);

        // five arrivals: narrow counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            raw_loop = 1'b1; tick(8);
            raw_loop = 1'b0; tick(8);
        end
        tick(5);
        check("sat_count_w2", 32'(vehicle_count2), 32'd3);
        check("sat_count_w8", 32'(vehicle_count), 32'd8);

        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
